pow2_data_path: RTL and testbench

POW2_DATA_PATH -- requirements
Module: pow2_data_path

---
 rtl/pow2_data_path.sv | 214 +++++++++++++++++++++
 tb/tb_pow2_data_path.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pow2_data_path.sv
// pow2_data_path: computes N = 2^k on the general mux/regfile/ALU/shifter datapath.
// Build option: define POW2_SAT_EN to saturate the result to 8'hFF when k >= 8.
module pow2_data_path (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] k_input,
    output logic [7:0] result,
    output logic       done
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        INIT  = 3'd2,
        SHIFT = 3'd3,
        DEC   = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS  = 3'd0,
        ALU_ADD   = 3'd1,
        ALU_SUB   = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_NOT_A = 3'd5,
        ALU_INC   = 3'd6,
        ALU_DEC   = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        SH_PASS  = 2'd0,
        SH_LEFT  = 2'd1,
        SH_RIGHT = 2'd2,
        SH_ROL   = 2'd3
    } shift_op_t;

    localparam logic [1:0] ACC = 2'd0;  // accumulator N
    localparam logic [1:0] CNT = 2'd1;  // remaining count k

    // Declaration initialisers make power-up match the reset state.
    state_t     state  = IDLE;
    logic       z      = 1'b0;
    logic       done_r = 1'b0;
    logic [7:0] regs [4] = '{default: 8'h00};

    // Datapath control
    logic      ie;
    logic      we;
    logic [1:0] wa;
    logic      rea;
    logic [1:0] ra_a;
    logic      reb;
    logic [1:0] ra_b;
    alu_op_t   alu_op;
    shift_op_t sh_op;

    // Datapath buses
    logic [7:0] a_bus;
    logic [7:0] b_bus;
    logic [7:0] alu_out;
    logic [7:0] dp_out;
    logic [7:0] wr_data;
    logic       sat_hit;

`ifdef POW2_SAT_EN
    assign sat_hit = (regs[CNT] > 8'd7);
`else
    assign sat_hit = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        ie     = 1'b0;
        we     = 1'b0;
        wa     = ACC;
        rea    = 1'b0;
        ra_a   = ACC;
        reb    = 1'b0;
        ra_b   = ACC;
        alu_op = ALU_PASS;
        sh_op  = SH_PASS;
        case (state)
            IDLE: begin
                // Port A disabled reads 0, so the pass path clears the accumulator.
                we = 1'b1;
            end
            LOAD: begin
                ie = 1'b1;
                we = 1'b1;
                wa = CNT;
            end
            INIT: begin
                we     = 1'b1;
                rea    = 1'b1;
                alu_op = ALU_INC;
                if (sat_hit) begin
                    rea    = 1'b0;
                    alu_op = ALU_NOT_A;
                end
            end
            SHIFT: begin
                we    = 1'b1;
                rea   = 1'b1;
                sh_op = SH_LEFT;
            end
            DEC: begin
                we     = 1'b1;
                wa     = CNT;
                rea    = 1'b1;
                ra_a   = CNT;
                alu_op = ALU_DEC;
            end
            DONE: begin
                rea = 1'b1;
            end
            default: ;
        endcase
    end

    // Two enabled read ports; a disabled port reads as zero.
    assign a_bus = rea ? regs[ra_a] : 8'h00;
    assign b_bus = reb ? regs[ra_b] : 8'h00;

    always_comb begin
        alu_out = a_bus;
        case (alu_op)
            ALU_PASS:  alu_out = a_bus;
            ALU_ADD:   alu_out = a_bus + b_bus;
            ALU_SUB:   alu_out = a_bus - b_bus;
            ALU_AND:   alu_out = a_bus & b_bus;
            ALU_OR:    alu_out = a_bus | b_bus;
            ALU_NOT_A: alu_out = ~a_bus;
            ALU_INC:   alu_out = a_bus + 8'd1;
            ALU_DEC:   alu_out = a_bus - 8'd1;
            default:   alu_out = a_bus;
        endcase
    end

    always_comb begin
        dp_out = alu_out;
        case (sh_op)
            SH_PASS:  dp_out = alu_out;
            SH_LEFT:  dp_out = {alu_out[6:0], 1'b0};
            SH_RIGHT: dp_out = {1'b0, alu_out[7:1]};
            SH_ROL:   dp_out = {alu_out[6:0], alu_out[7]};
            default:  dp_out = alu_out;
        endcase
    end

    assign wr_data = ie ? k_input : dp_out;

    // NOTE: the register file is cleared on reset because the FSM relies on known register contents after any abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[wa] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            z      <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    z     <= (k_input == 8'h00);
                    state <= INIT;
                end
                INIT: begin
                    if (z || sat_hit) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    state <= DEC;
                end
                DEC: begin
                    // dp_out carries the decremented count this cycle.
                    z <= (dp_out == 8'h00);
                    if (dp_out == 8'h00) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: ;
                default: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign done   = done_r;
    assign result = done_r ? dp_out : 8'bz;

endmodule

// File: tb/tb_pow2_data_path.sv
// Scoreboard bench for pow2_data_path: stimulus pushes expected {result, latency},
// a negedge monitor pops and compares whenever done rises.
module tb_pow2_data_path;
    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic [7:0] k_input = 8'h00;
    wire  [7:0] result;
    wire        done;

    pow2_data_path dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .k_input (k_input),
        .result  (result),
        .done    (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] value;
        int         latency;
        int         k;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_cur;
    int         n_vec      = 0;
    int         n_bad      = 0;
    int         edge_cnt   = 0;
    int         start_edge = 0;
    logic       done_q     = 1'b0;
    logic       holding    = 1'b0;
    logic [7:0] held       = 8'h00;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // An undriven bus reads as Z on 4-state simulators and resolves to 0 on 2-state ones.
    function automatic bit is_hiz(input logic [7:0] v);
        return $isunknown(v) || (v == 8'h00);
    endfunction

    // Monitor: compares on every done rise, checks the held value and the idle bus.
    always @(negedge clock) begin
        if (done && !done_q) begin
            check("pending_expectation", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e_cur = exp_q.pop_front();
                check($sformatf("result_k%0d", e_cur.k), int'(result), int'(e_cur.value));
                check($sformatf("latency_k%0d", e_cur.k), edge_cnt - start_edge, e_cur.latency);
                held    = e_cur.value;
                holding = 1'b1;
            end
        end else if (done && holding) begin
            check("result_held", int'(result), int'(held));
        end else if (!done) begin
            check("result_hiz", int'(is_hiz(result)), 1);
            holding = 1'b0;
        end
        done_q = done;
    end

    // Reset with start asserted; ends at a negedge with reset just released.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clock);
        check("done_in_reset", int'(done), 0);
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic launch(input logic [7:0] k);
        k_input = k;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start_edge = edge_cnt;
        start      = 1'b0;
    endtask

    task automatic run(input logic [7:0] k, input logic [7:0] ev, input int el);
        do_reset();
        exp_q.push_back('{value: ev, latency: el, k: int'(k)});
        launch(k);
        // LOAD samples k on the next edge; scramble it afterwards.
        @(posedge clock);
        #1;
        k_input = ~k;
        for (int i = 0; i < 600 && !done; i++) @(negedge clock);
        check($sformatf("done_within_budget_k%0d", k), int'(done), 1);
        if (!done) exp_q.delete();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1;
        check("init_done", int'(done), 0);
        check("init_hiz", int'(is_hiz(result)), 1);

        // Exponent sweep 0..7.
        run(8'd0, 8'h01, 2);
        run(8'd1, 8'h02, 4);
        run(8'd2, 8'h04, 6);
        run(8'd3, 8'h08, 8);
        run(8'd4, 8'h10, 10);
        run(8'd6, 8'h40, 14);
        run(8'd7, 8'h80, 16);

        // Out-of-range exponents.
`ifdef POW2_SAT_EN
        run(8'd9,   8'hFF, 2);
        run(8'd255, 8'hFF, 2);
`else
        run(8'd9,   8'h00, 20);
        run(8'd255, 8'h00, 512);
`endif

        // k=5, then poke start and k_input while in DONE.
        run(8'd5, 8'h20, 12);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            start   = ~start;
            k_input = 8'd1;
        end
        start = 1'b0;
        @(negedge clock);
        check("done_sticky", int'(done), 1);
        check("result_sticky", int'(result), 8'h20);

        // Abort k=6 with reset sampled five edges after start, then rerun with k=2.
        do_reset();
        launch(8'd6);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("done_after_abort", int'(done), 0);
        check("hiz_after_abort", int'(is_hiz(result)), 1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run(8'd2, 8'h04, 6);

        @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
